// File: rtl/csr_hpm_counters.sv
// Machine-mode mcycle/minstret/mhpmcounter CSR unit behind a registered request/response port.
// Defining CSR_HPM_OVF_IRQ_EN adds a registered ovf_irq_o output.
module csr_hpm_counters #(
  parameter int NUM_CNT  = 4,
  parameter int CNT_W    = 64,
  parameter int NUM_EVT  = 16,
  parameter int RETIRE_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  logic [1:0]          req_op_i,
  input  logic [11:0]         req_addr_i,
  input  logic [63:0]         req_wdata_i,
  output logic                rsp_valid_o,
  output logic [63:0]         rsp_rdata_o,
  output logic                rsp_exc_o,
  input  logic [RETIRE_W-1:0] retire_i,
  input  logic [NUM_EVT-1:0]  evt_i,
`ifdef CSR_HPM_OVF_IRQ_EN
  output logic                ovf_irq_o,
`endif
  output logic [NUM_CNT+2:0]  ovf_o
);

  // Slots follow the CSR address offset: 0 cycle, 1 reserved, 2 instret, 3.. hpm
  localparam int NC = NUM_CNT + 3;
  localparam logic [NC-1:0] SLOT_MASK = ~NC'(2);
  localparam logic [NC-1:0] HPM_MASK  = SLOT_MASK & ~NC'(7);

  localparam logic [6:0] PG_CNT = 7'h58;
  localparam logic [6:0] PG_SHD = 7'h60;
  localparam logic [6:0] PG_EVT = 7'h19;
  localparam logic [11:0] ADDR_INH = 12'h320;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  logic [CNT_W-1:0] cnt_q     [NC];
  logic [CNT_W-1:0] cnt_d     [NC];
  logic [7:0]       evt_sel_q [NC];
  logic [7:0]       evt_sel_d [NC];
  logic [NC-1:0]    inh_q, inh_d;
  logic [NC-1:0]    ovf_q, ovf_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [63:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_exc_q, rsp_exc_d;

  logic [NC-1:0]    sel;
  logic             is_cnt, is_shd, is_evt, is_inh;
  logic             legal, wr_en;
  logic [63:0]      old_val, new_val;

  always_comb begin
    sel = '0;
    for (int k = 0; k < NC; k++)
      sel[k] = SLOT_MASK[k] && (req_addr_i[4:0] == 5'(k));
    is_cnt = (req_addr_i[11:5] == PG_CNT) && (|sel);
    is_shd = (req_addr_i[11:5] == PG_SHD) && (|sel);
    is_evt = (req_addr_i[11:5] == PG_EVT) && (|(sel & HPM_MASK));
    is_inh = (req_addr_i == ADDR_INH);

    old_val = '0;
    for (int k = 0; k < NC; k++) begin
      if (sel[k]) begin
        if (is_cnt || is_shd)
          old_val = 64'(cnt_q[k]);
        else if (is_evt)
          old_val = 64'(evt_sel_q[k]);
      end
    end
    if (is_inh)
      old_val = 64'(inh_q);

    legal = is_cnt || is_evt || is_inh || (is_shd && (req_op_i == OP_READ));

    case (req_op_i)
      OP_WRITE: new_val = req_wdata_i;
      OP_SET:   new_val = old_val | req_wdata_i;
      OP_CLR:   new_val = old_val & ~req_wdata_i;
      default:  new_val = old_val;
    endcase

    // Set/clear with a zero operand is a pure read and must not disturb ovf
    wr_en = req_valid_i && legal && !is_shd &&
            ((req_op_i == OP_WRITE) ||
             (((req_op_i == OP_SET) || (req_op_i == OP_CLR)) && (|req_wdata_i)));

    rsp_valid_d = req_valid_i;
    rsp_rdata_d = (req_valid_i && legal) ? old_val : '0;
    rsp_exc_d   = req_valid_i && !legal;
  end

  logic [CNT_W:0] ret_cnt;
  logic [CNT_W:0] inc;
  logic [CNT_W:0] sum;

  always_comb begin
    ret_cnt = '0;
    inc     = '0;
    sum     = '0;
    for (int j = 0; j < RETIRE_W; j++)
      ret_cnt = ret_cnt + (CNT_W+1)'(retire_i[j]);

    for (int k = 0; k < NC; k++) begin
      inc = '0;
      if (k == 0) begin
        inc = (CNT_W+1)'(1);
      end else if (k == 2) begin
        inc = ret_cnt;
      end else if (k >= 3) begin
        for (int j = 0; j < NUM_EVT; j++)
          if (evt_sel_q[k] == 8'(j + 1))
            inc = (CNT_W+1)'(evt_i[j]);
      end
      sum = {1'b0, cnt_q[k]} + inc;

      cnt_d[k] = cnt_q[k];
      ovf_d[k] = ovf_q[k];
      if (SLOT_MASK[k] && !inh_q[k]) begin
        cnt_d[k] = sum[CNT_W-1:0];
        if (sum[CNT_W])
          ovf_d[k] = 1'b1;
      end
      // A CSR write overrides this cycle's increment and clears the sticky flag
      if (wr_en && is_cnt && sel[k]) begin
        cnt_d[k] = new_val[CNT_W-1:0];
        ovf_d[k] = 1'b0;
      end

      evt_sel_d[k] = evt_sel_q[k];
      if (wr_en && is_evt && sel[k])
        evt_sel_d[k] = new_val[7:0];
    end

    inh_d = (wr_en && is_inh) ? (new_val[NC-1:0] & SLOT_MASK) : inh_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NC; k++) begin
        cnt_q[k]     <= '0;
        evt_sel_q[k] <= '0;
      end
      inh_q       <= '0;
      ovf_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_exc_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        cnt_q[k]     <= cnt_d[k];
        evt_sel_q[k] <= evt_sel_d[k];
      end
      inh_q       <= inh_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_exc_q   <= rsp_exc_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_exc_o   = rsp_exc_q;
  assign ovf_o       = ovf_q;

`ifdef CSR_HPM_OVF_IRQ_EN
  logic ovf_irq_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      ovf_irq_q <= 1'b0;
    else
      ovf_irq_q <= |(ovf_d & ~inh_d);
  end

  assign ovf_irq_o = ovf_irq_q;
`endif

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Bench for csr_hpm_counters: directed literal checks plus randomized traffic compared
// every cycle against an arithmetic reference model of the counter CSRs.
module tb_csr_hpm_counters;
  localparam int NUM_CNT  = 4;
  localparam int CNT_W    = 32;
  localparam int NUM_EVT  = 16;
  localparam int RETIRE_W = 2;
  localparam int NS       = NUM_CNT + 3;
  localparam longint unsigned CMASK = (64'd1 << CNT_W) - 64'd1;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                req_valid_i = 1'b0;
  logic [1:0]          req_op_i = 2'b11;
  logic [11:0]         req_addr_i = '0;
  logic [63:0]         req_wdata_i = '0;
  logic                rsp_valid_o;
  logic [63:0]         rsp_rdata_o;
  logic                rsp_exc_o;
  logic [RETIRE_W-1:0] retire_i = '0;
  logic [NUM_EVT-1:0]  evt_i = '0;
  logic [NUM_CNT+2:0]  ovf_o;
`ifdef CSR_HPM_OVF_IRQ_EN
  logic                ovf_irq;
`endif

  csr_hpm_counters #(
    .NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT), .RETIRE_W(RETIRE_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_exc_o(rsp_exc_o),
    .retire_i(retire_i), .evt_i(evt_i),
`ifdef CSR_HPM_OVF_IRQ_EN
    .ovf_irq_o(ovf_irq),
`endif
    .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one entry per CSR address offset (offset 1 is never used)
  longint unsigned m_cnt [NS];
  int unsigned     m_evt [NS];
  longint unsigned m_inh;
  logic [NS-1:0]   m_ovf;
  logic            exp_valid, exp_exc;
  logic [63:0]     exp_rdata;

  function automatic bit is_ctr(input int s);
    return (s == 0) || (s == 2) || (s >= 3 && s < NUM_CNT + 3);
  endfunction

  task automatic model_step();
    int kind, slot, a, inc;
    bit legal, wr;
    longint unsigned old, nv, sum, inh_mask;
    a = int'(req_addr_i);
    kind = 0; slot = 0; old = 0;
    if (is_ctr(a - 'hB00)) begin kind = 1; slot = a - 'hB00; end
    else if (is_ctr(a - 'hC00)) begin kind = 2; slot = a - 'hC00; end
    else if (a >= 'h323 && a < 'h323 + NUM_CNT) begin kind = 3; slot = a - 'h320; end
    else if (a == 'h320) kind = 4;
    if (kind == 1 || kind == 2) old = m_cnt[slot];
    else if (kind == 3) old = longint'(m_evt[slot]);
    else if (kind == 4) old = m_inh;
    legal = (kind == 1) || (kind == 3) || (kind == 4) || (kind == 2 && req_op_i == 2'b11);
    wr = req_valid_i && legal && kind != 2 &&
         (req_op_i == 2'b00 || (req_op_i != 2'b11 && req_wdata_i != 0));
    if (req_op_i == 2'b00) nv = req_wdata_i;
    else if (req_op_i == 2'b01) nv = old | req_wdata_i;
    else nv = old & ~req_wdata_i;

    exp_valid = req_valid_i;
    exp_exc   = req_valid_i && !legal;
    exp_rdata = (req_valid_i && legal) ? old : 64'd0;

    for (int s = 0; s < NS; s++) begin
      if (s != 1 && !m_inh[s]) begin
        if (s == 0) inc = 1;
        else if (s == 2) inc = $countones(retire_i);
        else if (m_evt[s] >= 1 && m_evt[s] <= NUM_EVT) inc = int'(evt_i[m_evt[s] - 1]);
        else inc = 0;
        sum = m_cnt[s] + longint'(inc);
        if (sum > CMASK) begin
          m_ovf[s] = 1'b1;
          sum = sum & CMASK;
        end
        m_cnt[s] = sum;
      end
    end

    if (wr) begin
      inh_mask = ((64'd1 << NS) - 64'd1) & ~64'd2;
      if (kind == 1) begin
        m_cnt[slot] = nv & CMASK;
        m_ovf[slot] = 1'b0;
      end else if (kind == 3) begin
        m_evt[slot] = int'(nv & 64'hFF);
      end else begin
        m_inh = nv & inh_mask;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        for (int s = 0; s < NS; s++) begin
          m_cnt[s] = 0;
          m_evt[s] = 0;
        end
        m_inh = 0; m_ovf = '0;
        exp_valid = 1'b0; exp_exc = 1'b0; exp_rdata = '0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (chk_en && !rst_i) begin
        chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_valid));
        if (exp_valid) begin
          chk("rsp_rdata", rsp_rdata_o, exp_rdata);
          chk("rsp_exc", 64'(rsp_exc_o), 64'(exp_exc));
        end
        chk("ovf_o", 64'(ovf_o), 64'(m_ovf));
      end
    end
  end

  logic [63:0] rd;
  logic        ex;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the response cycle
  task automatic csr_acc(input logic [1:0] op, input logic [11:0] addr,
                         input logic [63:0] wd, output logic [63:0] r, output logic e);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_addr_i  = addr;
    req_wdata_i = wd;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    r = rsp_rdata_o;
    e = rsp_exc_o;
    chk("acc_rsp_valid", 64'(rsp_valid_o), 64'd1);
  endtask

  logic [11:0] ra;
  logic [63:0] rw;

  initial begin
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rdata", rsp_rdata_o, 64'd0);
    chk("rst_exc", 64'(rsp_exc_o), 64'd0);
    chk("rst_ovf", 64'(ovf_o), 64'd0);
    #6;
    rst_i  = 1'b0;
    chk_en = 1'b1;
    @(posedge clk_i);
    #1;
    tick(9);
    csr_acc(2'b11, 12'hB00, 64'd0, rd, ex);
    chk("mcycle_after_10", rd, 64'd10);
    chk("mcycle_exc", 64'(ex), 64'd0);

    csr_acc(2'b00, 12'h323, 64'd1, rd, ex);
    csr_acc(2'b00, 12'hB03, 64'hFFFF_FFFE, rd, ex);
    evt_i = 16'h0001;
    tick(3);
    evt_i = '0;
    csr_acc(2'b11, 12'hB03, 64'd0, rd, ex);
    chk("hpm3_wrapped", rd, 64'd1);
    chk("ovf3_set", 64'(ovf_o[3]), 64'd1);
    csr_acc(2'b00, 12'hB03, 64'd0, rd, ex);
    chk("ovf3_cleared", 64'(ovf_o[3]), 64'd0);

    retire_i = 2'b11;
    tick(4);
    retire_i = 2'b01;
    tick(2);
    retire_i = 2'b00;
    csr_acc(2'b11, 12'hC02, 64'd0, rd, ex);
    chk("minstret_shadow", rd, 64'd10);

    csr_acc(2'b00, 12'hB00, 64'd500, rd, ex);
    csr_acc(2'b01, 12'h320, 64'd1, rd, ex);
    csr_acc(2'b11, 12'hB00, 64'd0, rd, ex);
    chk("inhibit_first", rd, 64'd501);
    tick(5);
    csr_acc(2'b11, 12'hB00, 64'd0, rd, ex);
    chk("inhibit_frozen", rd, 64'd501);
    csr_acc(2'b11, 12'h320, 64'd0, rd, ex);
    chk("inhibit_read", rd, 64'd1);
    csr_acc(2'b10, 12'h320, 64'd1, rd, ex);

    csr_acc(2'b00, 12'h320, 64'hFFFF_FFFF, rd, ex);
    csr_acc(2'b00, 12'h320, 64'd0, rd, ex);
    chk("inhibit_mask", rd, 64'h7D);
    csr_acc(2'b00, 12'h324, 64'h1FF, rd, ex);
    csr_acc(2'b00, 12'h324, 64'd0, rd, ex);
    chk("event_trunc", rd, 64'hFF);

    csr_acc(2'b00, 12'hC00, 64'd5, rd, ex);
    chk("shadow_wr_exc", 64'(ex), 64'd1);
    chk("shadow_wr_rdata", rd, 64'd0);
    csr_acc(2'b11, 12'h7FF, 64'd0, rd, ex);
    chk("bad_addr_exc", 64'(ex), 64'd1);
    csr_acc(2'b11, 12'hB01, 64'd0, rd, ex);
    chk("reserved_b01_exc", 64'(ex), 64'd1);

    csr_acc(2'b00, 12'hB00, 64'hFFFF_FFFF_1234_5678, rd, ex);
    csr_acc(2'b11, 12'hB00, 64'd0, rd, ex);
    chk("cnt_width_trunc", rd, 64'h1234_5678);

    csr_acc(2'b00, 12'hB00, 64'd100, rd, ex);
    csr_acc(2'b11, 12'hB00, 64'd0, rd, ex);
    chk("write_wins", rd, 64'd100);
    csr_acc(2'b11, 12'hB00, 64'd0, rd, ex);
    chk("count_resumes", rd, 64'd101);

    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        0: ra = 12'hB00;
        1: ra = 12'hB02;
        2: ra = 12'(12'hB03 + $urandom_range(0, NUM_CNT - 1));
        3: ra = 12'hC00;
        4: ra = 12'hC02;
        5: ra = 12'(12'hC03 + $urandom_range(0, NUM_CNT - 1));
        6: ra = 12'(12'h323 + $urandom_range(0, NUM_CNT - 1));
        7: ra = 12'h320;
        8: ra = 12'($urandom);
        default: ra = ($urandom_range(0, 1) != 0) ? 12'hB01 : 12'(12'h323 + NUM_CNT);
      endcase
      case ($urandom_range(0, 3))
        0: rw = 64'd0;
        1: rw = 64'($urandom_range(0, 20));
        2: rw = 64'(32'hFFFF_FFF0 + $urandom_range(0, 15));
        default: rw = {$urandom, $urandom};
      endcase
      req_valid_i = ($urandom_range(0, 2) != 0);
      req_op_i    = 2'($urandom_range(0, 3));
      req_addr_i  = ra;
      req_wdata_i = rw;
      retire_i    = RETIRE_W'($urandom);
      evt_i       = NUM_EVT'($urandom);
      tick(1);
    end
    req_valid_i = 1'b0;
    retire_i    = '0;
    evt_i       = '0;
    tick(2);

    req_valid_i = 1'b1;
    req_op_i    = 2'b11;
    req_addr_i  = 12'hB00;
    tick(1);
    req_valid_i = 1'b0;
    chk("pre_reset_rsp_valid", 64'(rsp_valid_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("mid_reset_ovf", 64'(ovf_o), 64'd0);
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    tick(2);
    csr_acc(2'b11, 12'hB00, 64'd0, rd, ex);
    chk("mcycle_after_rerst", rd, 64'd3);
    csr_acc(2'b11, 12'h323, 64'd0, rd, ex);
    chk("event_after_rerst", rd, 64'd0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
